// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains an FWFT FIFO as framed valid/ready bursts (full or timeout-flushed).
// Define FIFO_RD_SKID_EN to register the stream through a 2-entry skid buffer.
module fifo_burst_reader #(
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_empty,
    input  logic [AW:0]   fifo_rd_space,
    output logic          fifo_rd_en,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_sop,
    output logic          m_eop,
    output logic [AW:0]   m_len,
    output logic          busy
);
    typedef enum logic {IDLE, BURST} state_t;
    localparam logic [AW:0] BL   = (AW+1)'(BURST_LEN);
    localparam logic [15:0] TMAX = (TIMEOUT == 0) ? 16'hffff : 16'(TIMEOUT - 1);
    state_t state, nxt;
    logic [15:0] tmo_cnt;
    logic [AW:0] beat_cnt;
    logic full_go, tmo_go, start, pop_word, last;
`ifdef FIFO_RD_SKID_EN
    logic [1:0] sk_cnt, wr_idx;
    logic [DW+1:0] sk0, sk1;
    logic sk_pop;
`endif
    always_comb begin
        full_go = state == IDLE && fifo_rd_space >= BL;
        tmo_go = state == IDLE && TIMEOUT != 0 && !fifo_empty && tmo_cnt == TMAX && fifo_rd_space != '0;
        last = beat_cnt == m_len - 1'b1;
`ifdef FIFO_RD_SKID_EN
        // a new burst waits for the previous one to leave the skid so m_len stays stable per burst
        start = (full_go || tmo_go) && sk_cnt == 2'd0;
        fifo_rd_en = state == BURST && !fifo_empty && sk_cnt != 2'd2;
        m_valid = sk_cnt != 2'd0;
        m_data = sk0[DW-1:0];
        m_sop = m_valid && sk0[DW+1];
        m_eop = m_valid && sk0[DW];
        sk_pop = m_valid && m_ready;
        wr_idx = sk_cnt - {1'b0, sk_pop};
        busy = state == BURST || sk_cnt != 2'd0;
`else
        start = full_go || tmo_go;
        m_valid = state == BURST && !fifo_empty;
        m_data = state == BURST ? fifo_dout : '0;
        m_sop = state == BURST && beat_cnt == '0;
        m_eop = state == BURST && last;
        fifo_rd_en = m_valid && m_ready;
        busy = state == BURST;
`endif
        pop_word = fifo_rd_en;
        nxt = state;
        if (state == IDLE && start) nxt = BURST;
        if (state == BURST && pop_word && last) nxt = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
            beat_cnt <= '0;
            m_len <= '0;
        end else begin
            tmo_cnt <= (state != IDLE || fifo_empty || start) ? 16'd0 :
                       (tmo_cnt == TMAX) ? tmo_cnt : tmo_cnt + 16'd1;
            if (start) m_len <= full_go ? BL : fifo_rd_space;
            if (state == BURST && pop_word) beat_cnt <= last ? '0 : beat_cnt + 1'b1;
        end
    end
`ifdef FIFO_RD_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sk_cnt <= '0;
            sk0 <= '0;
            sk1 <= '0;
        end else begin
            sk_cnt <= sk_cnt + {1'b0, fifo_rd_en} - {1'b0, sk_pop};
            if (sk_pop) sk0 <= sk1;
            if (fifo_rd_en && wr_idx == 2'd0) sk0 <= {beat_cnt == '0, last, fifo_dout};
            if (fifo_rd_en && wr_idx == 2'd1) sk1 <= {beat_cnt == '0, last, fifo_dout};
        end
    end
`endif
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed vectors and burst sequences against a behavioural FWFT FIFO.
module tb_fifo_burst_reader;
    localparam int DW = 8, AW = 4, BL = 4, TMO = 16;
    logic clk = 0, rst = 1;
    logic [DW-1:0] fifo_dout, m_data;
    logic fifo_empty, fifo_rd_en, m_valid, m_sop, m_eop, busy;
    logic m_ready = 0;
    logic [AW:0] fifo_rd_space, m_len;
    always #5 clk = ~clk;

    fifo_burst_reader #(.DW(DW), .AW(AW), .BURST_LEN(BL), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_space(fifo_rd_space), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop),
        .m_len(m_len), .busy(busy)
    );

    logic [DW-1:0] mem [16];
    logic [3:0] wp = 0, rp = 0;
    logic [AW:0] cnt = 0;
    logic wr_en = 0;
    logic [DW-1:0] wr_data = 0;
    logic pop;
    assign pop = fifo_rd_en && cnt != 0;
    assign fifo_empty = cnt == 0;
    assign fifo_dout = mem[rp];
    assign fifo_rd_space = cnt;
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= wr_data;
            wp <= wp + 4'd1;
        end
        if (pop) rp <= rp + 4'd1;
        cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(pop);
    end

    typedef struct packed {logic [DW-1:0] d; logic s; logic e; logic [AW:0] l;} beat_t;
    beat_t sb[$];
    beat_t pb;
    int rd_cnt = 0, viol = 0;
    logic pst = 0;
    // observe just before each rising edge, when the handshake is settled
    always begin
        @(negedge clk);
        #4;
        if (!rst) begin
            if (fifo_rd_en) begin
                rd_cnt++;
                if (!m_ready || fifo_empty) viol++;
            end
            if (pst && (!m_valid || {m_data, m_sop, m_eop} != {pb.d, pb.s, pb.e})) viol++;
            if (m_valid && m_ready) sb.push_back('{m_data, m_sop, m_eop, m_len});
            pst = m_valid && !m_ready;
            pb = '{m_data, m_sop, m_eop, m_len};
        end else pst = 0;
    end

    int n_vec = 0, n_err = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1;
            wr_data = base + DW'(i);
            @(negedge clk);
        end
        wr_en = 0;
    endtask

    task automatic wait_beats(input string nm, input int n, input int lim);
        int k = 0;
        while (sb.size() < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 64'(sb.size()), 64'(n));
    endtask

    task automatic chk_beat(input string nm, input int i, input beat_t exp);
        chk(nm, (i < sb.size()) ? 64'(sb[i]) : 64'hdead, 64'(exp));
    endtask

    typedef struct packed {logic rdy; logic vld; logic [DW-1:0] dat; logic sop; logic eop; logic rd; logic bsy;} vec_t;
    vec_t tv [6];

    initial begin
        int k;
        tv[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b1, 1'b1};
        tv[2] = '{1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[3] = '{1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[4] = '{1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b1};
        tv[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        repeat (2) @(negedge clk);
        chk("reset_outs", {m_valid, fifo_rd_en, m_data, m_sop, m_eop}, '0);
        chk("reset_len", m_len, 0);
        chk("reset_busy", busy, 0);
        rst = 0;
        @(negedge clk);

        wr(8'hA0, 4);
        for (int i = 0; i < 6; i++) begin
            m_ready = tv[i].rdy;
            #1;
            chk($sformatf("t1_row%0d", i), {m_valid, m_valid ? m_data : 8'h00, m_sop, m_eop, fifo_rd_en, busy},
                {tv[i].vld, tv[i].dat, tv[i].sop, tv[i].eop, tv[i].rd, tv[i].bsy});
            if (tv[i].vld) chk($sformatf("t1_len%0d", i), m_len, 4);
            @(negedge clk);
        end
        chk("t1_rd_pulses", rd_cnt, 4);
        chk("t1_fifo_empty", cnt, 0);

        sb.delete();
        wr(8'hB0, 2);
        k = 0;
        while (!m_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("t2_start_delay", 64'(1 + k), 16);
        chk("t2_len", m_len, 2);
        wait_beats("t2_beats", 2, 20);
        chk_beat("t2_b0", 0, '{8'hB0, 1'b1, 1'b0, 5'd2});
        chk_beat("t2_b1", 1, '{8'hB1, 1'b0, 1'b1, 5'd2});
        chk("t2_fifo_empty", cnt, 0);

        sb.delete();
        wr(8'hC0, 10);
        wait_beats("t3_beats", 10, 200);
        for (int i = 0; i < 10; i++)
            chk_beat($sformatf("t3_b%0d", i), i, '{8'hC0 + 8'(i), i == 0 || i == 4 || i == 8,
                     i == 3 || i == 7 || i == 9, (i < 8) ? 5'd4 : 5'd2});
        chk("t3_fifo_empty", cnt, 0);

        sb.delete();
        rd_cnt = 0;
        m_ready = 0;
        wr(8'hD0, 4);
        k = 0;
        while (sb.size() < 4 && k < 200) begin
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        m_ready = 1;
        chk("t4_beats", sb.size(), 4);
        for (int i = 0; i < 4; i++)
            chk_beat($sformatf("t4_b%0d", i), i, '{8'hD0 + 8'(i), i == 0, i == 3, 5'd4});
        @(negedge clk);
        chk("t4_rd_pulses", rd_cnt, 4);
        chk("t4_protocol", viol, 0);

        sb.delete();
        wr(8'hE0, 4);
        k = 0;
        while (sb.size() < 2 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("t5_two_beats", sb.size(), 2);
        rst = 1;
        #1;
        chk("t5_rst_outs", {m_valid, fifo_rd_en, m_data, m_sop, m_eop, m_len, busy}, '0);
        @(negedge clk);
        rst = 0;
        wait_beats("t5_beats", 4, 100);
        chk_beat("t5_b1_no_eop", 1, '{8'hE1, 1'b0, 1'b0, 5'd4});
        chk_beat("t5_b2", 2, '{8'hE2, 1'b1, 1'b0, 5'd2});
        chk_beat("t5_b3", 3, '{8'hE3, 1'b0, 1'b1, 5'd2});
        chk("t5_fifo_empty", cnt, 0);
        chk("t5_protocol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
